// File: rtl/traffic_light_controller_nphase_pkg.sv
// Shared lamp codes and controller state encoding.
package tlc_pkg;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;
  localparam logic [1:0] LAMP_OFF    = 2'b11;

  typedef enum logic [1:0] {
    ALL_RED,
    GREEN,
    YELLOW,
    FLASH
  } tlc_state_t;

endpackage

// File: rtl/traffic_light_controller_nphase_if.sv
// Sensor/flash inputs and lamp/status outputs of the intersection controller.
interface tlc_if #(
  parameter int NUM_PHASES = 2
);
  localparam int PIDX_W = $clog2(NUM_PHASES);

  logic [NUM_PHASES-1:0]   sensor;
  logic                    flash_req;
  logic [2*NUM_PHASES-1:0] lights;
  logic [PIDX_W-1:0]       phase_idx;
  logic                    in_flash;

  // Environment side: drives sensors and flash request, observes lamps.
  modport master (
    output sensor, flash_req,
    input  lights, phase_idx, in_flash
  );

  // Controller side.
  modport slave (
    input  sensor, flash_req,
    output lights, phase_idx, in_flash
  );
endinterface

// File: rtl/traffic_light_controller_nphase_next_phase.sv
// Round-robin demand arbiter: first latched phase after cur_idx, else cur_idx+1.
module tlc_next_phase #(
  parameter int NUM_PHASES = 2,
  parameter int PIDX_W     = $clog2(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] demand,
  input  logic [PIDX_W-1:0]     cur_idx,
  output logic [PIDX_W-1:0]     next_idx
);

  logic [PIDX_W:0] cand;
  logic            found;

  // Scan the other phases in wrap order; the current phase itself is never
  // picked by demand, so a phase that just dwelled cannot immediately repeat.
  always_comb begin
    found = 1'b0;
    cand  = {1'b0, cur_idx} + (PIDX_W+1)'(1);
    if (cand >= (PIDX_W+1)'(NUM_PHASES)) cand = cand - (PIDX_W+1)'(NUM_PHASES);
    next_idx = cand[PIDX_W-1:0];
    for (int k = 1; k < NUM_PHASES; k++) begin
      cand = {1'b0, cur_idx} + (PIDX_W+1)'(k);
      if (cand >= (PIDX_W+1)'(NUM_PHASES)) cand = cand - (PIDX_W+1)'(NUM_PHASES);
      if (!found && demand[cand[PIDX_W-1:0]]) begin
        found    = 1'b1;
        next_idx = cand[PIDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/traffic_light_controller_nphase.sv
// Actuated N-phase traffic light controller: GREEN/YELLOW/ALL_RED per phase,
// sensor-extended green, idle-phase skipping and a blinking flash mode.
module traffic_light_controller_nphase #(
  parameter int NUM_PHASES = 2,
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 8,
  parameter int GREEN_MAX  = 20,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 2,
  parameter int FLASH_HALF = 4
) (
  input  logic clk,
  input  logic reset,
  tlc_if.slave bus
);

  localparam int PIDX_W = $clog2(NUM_PHASES);

  tlc_pkg::tlc_state_t     state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PIDX_W-1:0]       phase_q, phase_d;
  logic [NUM_PHASES-1:0]   demand_q, demand_d;
  logic                    blink_q, blink_d;
  logic [PIDX_W-1:0]       next_phase;
  logic [2*NUM_PHASES-1:0] lights;

  tlc_next_phase #(
    .NUM_PHASES(NUM_PHASES),
    .PIDX_W    (PIDX_W)
  ) u_next_phase (
    .demand  (demand_q),
    .cur_idx (phase_q),
    .next_idx(next_phase)
  );

  // State, dwell counter, served phase, demand latches and blink register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= tlc_pkg::ALL_RED;
      cnt_q    <= '0;
      phase_q  <= PIDX_W'(NUM_PHASES-1);
      demand_q <= '0;
      blink_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      demand_q <= demand_d;
      blink_q  <= blink_d;
    end
  end

  // Next-state logic; every state change clears the dwell counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    blink_d = blink_q;
    for (int i = 0; i < NUM_PHASES; i++)
      demand_d[i] = demand_q[i] |
                    (bus.sensor[i] & ~(state_q == tlc_pkg::GREEN && phase_q == PIDX_W'(i)));
    case (state_q)
      tlc_pkg::ALL_RED: begin
        if (cnt_q == CNT_W'(ALL_RED-1)) begin
          cnt_d = '0;
          if (bus.flash_req) begin
            state_d = tlc_pkg::FLASH;
            blink_d = 1'b0;
          end else begin
            state_d              = tlc_pkg::GREEN;
            phase_d              = next_phase;
            demand_d[next_phase] = 1'b0;  // entry clear beats a same-cycle set
          end
        end
      end
      tlc_pkg::GREEN: begin
        if (bus.flash_req ||
            (cnt_q >= CNT_W'(GREEN_MIN-1) && !bus.sensor[phase_q]) ||
            cnt_q == CNT_W'(GREEN_MAX-1)) begin
          state_d = tlc_pkg::YELLOW;
          cnt_d   = '0;
        end
      end
      tlc_pkg::YELLOW: begin
        if (cnt_q == CNT_W'(YELLOW-1)) begin
          state_d = tlc_pkg::ALL_RED;
          cnt_d   = '0;
        end
      end
      tlc_pkg::FLASH: begin
        if (!bus.flash_req) begin
          // Park on the last phase so the round-robin restarts at phase 0.
          state_d = tlc_pkg::ALL_RED;
          cnt_d   = '0;
          phase_d = PIDX_W'(NUM_PHASES-1);
          blink_d = 1'b0;
        end else if (cnt_q == CNT_W'(FLASH_HALF-1)) begin
          cnt_d   = '0;
          blink_d = ~blink_q;
        end
      end
      default: begin
        state_d = tlc_pkg::ALL_RED;
        cnt_d   = '0;
      end
    endcase
  end

  // Lamp decode from registered state only.
  always_comb begin
    lights = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      case (state_q)
        tlc_pkg::GREEN:  lights[2*i +: 2] = (phase_q == PIDX_W'(i)) ? tlc_pkg::LAMP_GREEN  : tlc_pkg::LAMP_RED;
        tlc_pkg::YELLOW: lights[2*i +: 2] = (phase_q == PIDX_W'(i)) ? tlc_pkg::LAMP_YELLOW : tlc_pkg::LAMP_RED;
        tlc_pkg::FLASH:  lights[2*i +: 2] = blink_q ? tlc_pkg::LAMP_OFF : tlc_pkg::LAMP_RED;
        default:         lights[2*i +: 2] = tlc_pkg::LAMP_RED;
      endcase
    end
  end

  assign bus.lights    = lights;
  assign bus.phase_idx = phase_q;
  assign bus.in_flash  = (state_q == tlc_pkg::FLASH);

endmodule

// File: tb/tb_traffic_light_controller_nphase.sv
// Scoreboard bench: a 2-phase and a 4-phase controller share random/directed
// stimulus; a timeline model predicts each cycle's lamps and a monitor compares.
module tb_traffic_light_controller_nphase;

  localparam int GMIN = 8, GMAX = 20, YEL = 3, AR = 2, FH = 4;
  localparam int M_CLR = 0, M_GRN = 1, M_YEL = 2, M_FL = 3;

  typedef struct {
    int       mode;
    int       t;     // cycles already spent in the current interval
    int       ph;
    bit [3:0] dem;
  } mdl_t;

  typedef struct {
    logic [7:0] lights;
    int         ph;
    bit         fl;
  } exp_t;

  logic     clk = 1'b0;
  logic     reset;
  bit [3:0] sens;
  bit       fr;
  int       checks = 0;
  int       errors = 0;
  mdl_t     m2, m4;
  exp_t     q2[$], q4[$];

  tlc_if #(.NUM_PHASES(2)) if2 ();
  tlc_if #(.NUM_PHASES(4)) if4 ();

  assign if2.sensor    = sens[1:0];
  assign if2.flash_req = fr;
  assign if4.sensor    = sens;
  assign if4.flash_req = fr;

  traffic_light_controller_nphase #(.NUM_PHASES(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  traffic_light_controller_nphase #(.NUM_PHASES(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

  always #5 clk = ~clk;

  // Advance the intersection timeline by one cycle.
  function automatic void mstep(inout mdl_t m, input int n, input bit rst,
                                input bit [3:0] s, input bit f);
    bit [3:0] dn;
    int       p;
    bit       hit;
    if (rst) begin
      m.mode = M_CLR; m.t = 0; m.ph = n - 1; m.dem = '0;
      return;
    end
    dn = m.dem;
    for (int i = 0; i < n; i++)
      if (s[i] && !(m.mode == M_GRN && m.ph == i)) dn[i] = 1'b1;
    case (m.mode)
      M_CLR: begin
        if (m.t + 1 >= AR) begin
          m.t = 0;
          if (f) m.mode = M_FL;
          else begin
            p = (m.ph + 1) % n;
            hit = 1'b0;
            for (int k = 1; k < n; k++)
              if (!hit && m.dem[(m.ph + k) % n]) begin p = (m.ph + k) % n; hit = 1'b1; end
            m.mode = M_GRN; m.ph = p; dn[p] = 1'b0;
          end
        end else m.t++;
      end
      M_GRN: begin
        if (f || (m.t + 1 >= GMIN && !s[m.ph]) || m.t + 1 >= GMAX) begin
          m.mode = M_YEL; m.t = 0;
        end else m.t++;
      end
      M_YEL: begin
        if (m.t + 1 >= YEL) begin m.mode = M_CLR; m.t = 0; end
        else m.t++;
      end
      default: begin
        if (!f) begin m.mode = M_CLR; m.t = 0; m.ph = n - 1; end
        else m.t++;
      end
    endcase
    m.dem = dn;
  endfunction

  function automatic exp_t mout(input mdl_t m, input int n);
    exp_t e;
    e.lights = '0;
    e.ph     = m.ph;
    e.fl     = (m.mode == M_FL);
    for (int i = 0; i < n; i++) begin
      if (m.mode == M_GRN && i == m.ph)      e.lights[2*i +: 2] = 2'b10;
      else if (m.mode == M_YEL && i == m.ph) e.lights[2*i +: 2] = 2'b01;
      else if (m.mode == M_FL && ((m.t / FH) % 2) == 1) e.lights[2*i +: 2] = 2'b11;
    end
    return e;
  endfunction

  // Model sees exactly what the DUTs sample on this edge.
  always @(posedge clk) begin
    mstep(m2, 2, reset, sens, fr);
    q2.push_back(mout(m2, 2));
    mstep(m4, 4, reset, sens, fr);
    q4.push_back(mout(m4, 4));
  end

  // Monitor: registered outputs are stable at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q2.size() > 0) begin
      e = q2.pop_front();
      checks++;
      if (if2.lights !== e.lights[3:0] || if2.phase_idx !== 1'(e.ph) || if2.in_flash !== e.fl) begin
        errors++;
        $display("FAIL np2 t=%0t got lights=%b idx=%0d flash=%b exp lights=%b idx=%0d flash=%b",
                 $time, if2.lights, if2.phase_idx, if2.in_flash, e.lights[3:0], e.ph, e.fl);
      end
    end
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checks++;
      if (if4.lights !== e.lights || if4.phase_idx !== 2'(e.ph) || if4.in_flash !== e.fl) begin
        errors++;
        $display("FAIL np4 t=%0t got lights=%b idx=%0d flash=%b exp lights=%b idx=%0d flash=%b",
                 $time, if4.lights, if4.phase_idx, if4.in_flash, e.lights, e.ph, e.fl);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until the chosen model reaches mode/phase/time.
  task automatic wait_m(input bit four, input int mode, input int ph, input int t, input string nm);
    int n = 0;
    while (n < 300 && !(four ? (m4.mode == mode && m4.ph == ph && m4.t == t)
                             : (m2.mode == mode && m2.ph == ph && m2.t == t))) begin
      cyc();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_%s timed out after %0d cycles, required mode=%0d ph=%0d t=%0d", nm, n, mode, ph, t);
    end
  endtask

  initial begin
    reset = 1'b1; sens = '0; fr = 1'b0;
    cyc(3);
    reset = 1'b0;
    // idle recall sequence
    cyc(45);
    // sensor 0 held: max green, then phase 1 still served
    sens = 4'b0001;
    cyc(60);
    sens = '0;
    cyc(20);
    // sensor 0 drops at green cycle 12
    wait_m(1'b0, M_GRN, 0, 0, "g0");
    sens[0] = 1'b1;
    cyc(12);
    sens[0] = 1'b0;
    cyc(20);
    // 4-phase skip: one-cycle pulse on sensor 2 during phase 0 green
    wait_m(1'b1, M_GRN, 0, 3, "np4_g0");
    sens[2] = 1'b1;
    cyc();
    sens[2] = 1'b0;
    cyc(60);
    // flash request at green cycle 2, then release
    wait_m(1'b0, M_GRN, 0, 2, "fl");
    fr = 1'b1;
    cyc(30);
    fr = 1'b0;
    cyc(30);
    // reset during yellow cycle 1
    wait_m(1'b0, M_YEL, m2.ph, 1, "yel");
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc(40);
    // randomized traffic with occasional flash and reset
    for (int i = 0; i < 1500; i++) begin
      sens = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 120) == 0) fr = ~fr;
      reset = ($urandom_range(0, 400) == 0);
      cyc();
    end
    reset = 1'b0; fr = 1'b0; sens = '0;
    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
